rr_resource_arbiter: RTL and testbench
======================================

# rr_resource_arbiter

Round-robin arbiter that shares one downstream resource among `N` requesters. It uses a registered one-hot grant, a per-grant hold limit and a mandatory release cycle between owners. It sits between the requester ports and the shared datapath. It replaces ad-hoc fixed-priority selection with fair, starvation-free rotation.

## Interface
- `N`, 4: number of requesters, 2..16.
- `ID_W`, 2: width of `gnt_id`; must equal `$clog2(N)`.
- `HOLD_W`, 8: width of the hold counter.
- `MAX_HOLD`, 16: maximum consecutive grant cycles, 1..2^HOLD_W-1; 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `req`  in  N  request level per requester; the owner keeps it high while using the resource.
- `gnt`  out  N  registered one-hot grant; all-zero when no owner.
- `gnt_valid`  out  1  OR of `gnt`, registered.
- `gnt_id`  out  ID_W  index of current owner; 0 when `gnt_valid`=0.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.
- `busy`  out  1  high in GRANT and RELEASE states.

## Operation
State machine, 2-bit state register:
- **IDLE**
  - If `req`≠0, select the first set bit scanning from `ptr` upward, wrapping from N-1 to 0.
  - Load `gnt`, `gnt_id` and `owner`; clear `hold_cnt`; go to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT**
  - `hold_cnt` increments every cycle and saturates at all-ones.
  - If `req[owner]`=0, go to RELEASE.
  - Else if `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`-1, go to RELEASE and assert `timeout` in the next cycle.
  - Requests from other requesters are ignored; no preemption.
- **RELEASE**
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0.
  - `ptr` ← (`owner`+1) mod N; go to IDLE.
- Encoding 2'b11 is illegal; it recovers to IDLE with `gnt`=0.

Rotation and ownership rules:
- `ptr` resets to 0. It updates only in RELEASE, so the last owner is always the lowest priority.
- A timed-out requester still holding `req` is eligible again after rotation. If it is the sole requester, it is regranted.
- At most one bit of `gnt` is ever set. `gnt` never changes directly from one owner to another; there is always at least one all-zero cycle between owners.

Reset (async assert, any state): state=IDLE, `ptr`=0, `owner`=0, `hold_cnt`=0. All outputs are 0: `gnt`, `gnt_valid`, `gnt_id`, `timeout` and `busy`. Deassertion is synchronised externally; the first arbitration happens at the first edge after deassertion.

## Timing
- Grant latency:
  - `req[i]` sampled high in IDLE at edge k.
  - `gnt[i]`, `gnt_valid`, `gnt_id`=i and `busy` are high from edge k.
- Release latency:
  - `req[owner]` sampled low at edge k (in GRANT) → RELEASE after edge k, so `gnt`=0 from edge k.
  - IDLE after edge k+1.
  - Earliest next grant at edge k+2.
- Hold limit: a continuously requesting owner sees `gnt` high for exactly `MAX_HOLD` cycles, then `timeout`=1 for one cycle coincident with RELEASE.
- Owner-to-owner turnaround: minimum 2 cycles with `gnt`=0.
- Simultaneous events:
  - Owner drops `req` on the timeout cycle → release is normal and `timeout` stays 0.
  - New requests arriving during RELEASE are considered in the following IDLE cycle.

## Test plan
- **Single requester, N=4:** `req`=4'b0100 held 5 cycles, then dropped → `gnt`=4'b0100 and `gnt_id`=2 one cycle after the request. `gnt` goes to 0 one cycle after the drop; `ptr`=3.
- **All requesting from reset:** `req`=4'b1111, each owner drops `req` 3 cycles after its grant and re-raises it → grant order is 0,1,2,3,0. There are 2 idle cycles between grants and never two `gnt` bits set.
- **Timeout, MAX_HOLD=16:** `req`=4'b0010 held for 40 cycles → `gnt[1]` high for exactly 16 cycles and `timeout` pulses once. `gnt[1]` returns 2 cycles later; the pattern repeats.
- **Timeout fairness:** `req`=4'b0011 both held → owners alternate 0,1,0,1, each for 16 cycles, with a `timeout` pulse at every revoke.
- **Wrap-around:** owner 3 releases while `req`=4'b1001 → next grant goes to requester 0, `gnt_id`=0.
- **Reset mid-grant:** `rst_n` pulled low asynchronously while `gnt`=4'b0100 → all outputs 0 immediately, without waiting for a clock edge. After release with `req`=4'b0110, the first grant goes to requester 1 (`ptr`=0).

Source files
------------

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin owner selection for one shared resource, with a hold limit
// and a mandatory all-zero release cycle between owners.
module rr_resource_arbiter #(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            timeout,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, RELEASE = 2'b10} state_t;
  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);
  state_t state, state_d;
  logic [ID_W-1:0] ptr, ptr_d, owner, owner_d, sel, id_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [N-1:0] gnt_d;
  logic [2*N-1:0] rot;
  logic gv_d, to_d, found;
  assign rot = {req, req} >> ptr;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sel = ID_W'((int'(ptr) + i) % N);
      end
    end
  end
  // A dropped request wins over the hold limit, so timeout only fires while req is still high.
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    owner_d = owner;
    hold_d = hold_cnt;
    gnt_d = gnt;
    gv_d = gnt_valid;
    id_d = gnt_id;
    to_d = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_d = GRANT;
        owner_d = sel;
        id_d = sel;
        gnt_d = N'(1) << sel;
        gv_d = 1'b1;
        hold_d = '0;
      end
      GRANT: begin
        hold_d = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
        if (!req[owner] || (MAX_HOLD != 0 && hold_cnt == LIMIT)) begin
          state_d = RELEASE;
          gnt_d = '0;
          gv_d = 1'b0;
          id_d = '0;
          to_d = req[owner];
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
        gnt_d = '0;
        gv_d = 1'b0;
        id_d = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d = '0;
        gv_d = 1'b0;
        id_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      owner <= owner_d;
      hold_cnt <= hold_d;
      gnt <= gnt_d;
      gnt_valid <= gv_d;
      gnt_id <= id_d;
      timeout <= to_d;
    end
  end
  assign busy = (state == GRANT) || (state == RELEASE);
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: event-timeline reference model feeds a scoreboard queue; a negedge
// monitor pops one expected output set per cycle and compares it with the arbiter.
module tb_rr_resource_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic gnt_valid, timeout, busy;
  logic [1:0] gnt_id;
  typedef struct packed {
    logic [N-1:0] gnt;
    logic         gv;
    logic [1:0]   id;
    logic         to;
    logic         busy;
  } out_t;
  out_t sb[$];
  out_t got, want;
  int total = 0, bad = 0;
  int m_owner = -1, m_ptr = 0, m_cnt = 0, m_cool = 0;

  rr_resource_arbiter #(.N(N), .ID_W(2), .HOLD_W(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: an owner lasts until its request drops or MAX_HOLD cycles pass; after that one
  // dead cycle follows before the next arbitration, which scans upward from the last owner + 1.
  task automatic model_step(output out_t e);
    logic to;
    to = 1'b0;
    if (m_owner >= 0) begin
      m_cnt++;
      if (!req[m_owner] || (MAX_HOLD != 0 && m_cnt == MAX_HOLD)) begin
        to = req[m_owner];
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt = 0;
        end
    end
    e.gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.gv = (m_owner >= 0);
    e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.to = to;
    e.busy = (m_owner >= 0) || (m_cool > 0);
  endtask

  // hold < 0: random requests; hold > 0: owner drops after hold cycles; hold == 0: follow pat.
  task automatic step(input logic [N-1:0] pat, input int hold);
    logic [N-1:0] r;
    out_t e;
    @(posedge clk);
    model_step(e);
    sb.push_back(e);
    #1;
    r = (hold < 0) ? N'($urandom) : pat;
    if (m_owner >= 0) begin
      if (hold < 0) r[m_owner] = ($urandom_range(0, 9) != 0);
      else if (hold > 0 && m_cnt + 1 >= hold) r[m_owner] = 1'b0;
    end
    req = r;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_gnt_valid", int'(gnt_valid), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_busy", int'(busy), 0);
    req = r;
    m_owner = -1;
    m_ptr = 0;
    m_cnt = 0;
    m_cool = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      got = {gnt, gnt_valid, gnt_id, timeout, busy};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty got gnt=%b with no expected entry", gnt);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL cycle t=%0t got gnt=%b v=%b id=%0d to=%b busy=%b want gnt=%b v=%b id=%0d to=%b busy=%b",
                   $time, got.gnt, got.gv, got.id, got.to, got.busy,
                   want.gnt, want.gv, want.id, want.to, want.busy);
        end
      end
      total++;
      if ($countones(gnt) > 1) begin
        bad++;
        $display("FAIL onehot got gnt=%b want at most one bit", gnt);
      end
    end
  end

  initial begin
    do_reset('0);
    repeat (5) step(4'b0100, 0);
    repeat (5) step(4'b0000, 0);
    do_reset(4'b1111);
    repeat (30) step(4'b1111, 3);
    repeat (40) step(4'b0010, 0);
    repeat (3) step(4'b0000, 0);
    repeat (70) step(4'b0011, 0);
    repeat (3) step(4'b0000, 0);
    repeat (3) step(4'b1000, 0);
    repeat (8) step(4'b1001, 2);
    repeat (3) step(4'b0000, 0);
    repeat (4) step(4'b0100, 0);
    chk("pre_rst_gnt", int'(gnt), 4);
    do_reset(4'b0110);
    repeat (12) step(4'b0110, 4);
    repeat (2000) step('0, -1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
